// File: rtl/scs_pkg.sv
// Shared constants and state encoding for the frame checksum checker and generator.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package scs_pkg;

  // Header bytes holding the little-endian frame length.
  localparam int PAYLOAD_ADDR_1 = 4;
  localparam int PAYLOAD_ADDR_2 = 5;
  // Shortest legal frame still has to cover both length bytes.
  localparam int MIN_LEN        = 6;
  // Length math is one bit wider than the length field so L+1 cannot wrap.
  localparam int LEN_W          = 17;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    RXLO = 3'd2,
    RXHI = 3'd3,
    FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/scs_accum.sv
// Weighted 16-bit checksum accumulator: adds data << sel, wrapping modulo 2^16.
// Latency: sum updates on the clock edge after i_en.
// Backpressure: none; the caller decides when each byte is valid via i_en.
module scs_accum #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_data,
  output logic [15:0]       o_sum
);

  logic [15:0] w_term;
  logic [15:0] r_sum;

  // Byte weight is 1, 2, 4 or 8 depending on its position within a 4-byte group.
  always_comb begin
    w_term = 16'(i_data) << i_sel;
  end

  // Running sum; carries out of bit 15 are intentionally dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum <= 16'd0;
    end else if (i_clr) begin
      r_sum <= 16'd0;
    end else if (i_en) begin
      r_sum <= r_sum + w_term;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/scs_check.sv
// Reads a length-prefixed frame from a synchronous RAM and compares its weighted checksum.
// Latency: done pulses L+3 cycles after the start sample (7 cycles on a bad length).
// Backpressure: none; mem_ready is only sampled in IDLE and ignored while busy.
module scs_check
  import scs_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mem_ready,
  output logic [RAM_ADDR_BITS-1:0] address,
  input  logic [RAM_WIDTH-1:0]     mem_output,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     err_len,
  output logic [15:0]              checksum_calc,
  output logic [15:0]              checksum_rx
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'((1 << RAM_ADDR_BITS) - 2);

  state_t                   r_state;
  state_t                   w_next;
  logic [RAM_ADDR_BITS-1:0] r_addr;
  logic [RAM_ADDR_BITS-1:0] w_idx;
  logic [15:0]              r_len;
  logic [15:0]              r_rx;
  logic                     r_pass;
  logic                     r_err;
  logic [7:0]               w_byte;
  logic [LEN_W-1:0]         w_len;
  logic [LEN_W-1:0]         w_addr_ext;
  logic                     w_start;
  logic                     w_len_known;
  logic                     w_len_bad;
  logic                     w_last;
  logic                     w_acc_en;

  // Data on mem_output belongs to the address presented one cycle earlier.
  assign w_byte      = mem_output[7:0];
  assign w_idx       = r_addr - RAM_ADDR_BITS'(1);
  assign w_addr_ext  = LEN_W'(r_addr);
  assign w_start     = (r_state == IDLE) && mem_ready;
  assign w_len_known = (r_state == RUN) && (w_idx == RAM_ADDR_BITS'(PAYLOAD_ADDR_2));
  // The high length byte is used straight off the bus in the cycle it arrives.
  assign w_len       = w_len_known ? {1'b0, w_byte, r_len[7:0]} : {1'b0, r_len};
  assign w_len_bad   = (w_len < LEN_W'(MIN_LEN)) || (w_len > MAX_LEN);
  // Before the length is complete r_len holds stale data, so gate on MIN_LEN.
  assign w_last      = (w_addr_ext >= LEN_W'(MIN_LEN)) && (w_addr_ext == w_len);

  // Next-state decode; RUN is the only state that feeds the accumulator.
  always_comb begin
    w_next   = r_state;
    w_acc_en = 1'b0;
    case (r_state)
      IDLE: if (mem_ready) w_next = RUN;
      RUN: begin
        w_acc_en = 1'b1;
        if (w_len_known && w_len_bad) begin
          w_next = FIN;
        end else if (w_last) begin
          w_next = RXLO;
        end
      end
      RXLO:    w_next = RXHI;
      RXHI:    w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Read address walks forward while data is still needed and parks at 0 otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_next == RUN || w_next == RXLO || w_next == RXHI) begin
      r_addr <= r_addr + RAM_ADDR_BITS'(1);
    end else begin
      r_addr <= '0;
    end
  end

  // Length capture, received checksum capture and the pass/err verdict.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_len  <= 16'd0;
      r_rx   <= 16'd0;
      r_pass <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_rx   <= 16'd0;
        r_pass <= 1'b0;
        r_err  <= 1'b0;
      end
      if (r_state == RUN && w_idx == RAM_ADDR_BITS'(PAYLOAD_ADDR_1)) begin
        r_len[7:0] <= w_byte;
      end
      if (w_len_known) begin
        r_len[15:8] <= w_byte;
        if (w_len_bad) begin
          r_err  <= 1'b1;
          r_pass <= 1'b0;
        end
      end
      if (r_state == RXLO) begin
        r_rx[7:0] <= w_byte;
      end
      if (r_state == RXHI) begin
        r_rx[15:8] <= w_byte;
        r_pass     <= (checksum_calc == {w_byte, r_rx[7:0]});
      end
    end
  end

  scs_accum #(
    .DATA_W (RAM_WIDTH)
  ) u_accum (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_start),
    .i_en   (w_acc_en),
    .i_sel  (w_idx[1:0]),
    .i_data (mem_output),
    .o_sum  (checksum_calc)
  );

  assign address     = r_addr;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == FIN);
  assign pass        = r_pass;
  assign err_len     = r_err;
  assign checksum_rx = r_rx;

endmodule

// File: tb/tb_scs_check.sv
// Self-checking bench for scs_check: directed table, random frames vs a reference model, corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_scs_check;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_ready;
  logic [9:0]  address;
  logic [7:0]  mem_output;
  logic        busy;
  logic        done;
  logic        pass;
  logic        err_len;
  logic [15:0] checksum_calc;
  logic [15:0] checksum_rx;

  logic [7:0]  mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  scs_check #(
    .RAM_WIDTH     (8),
    .RAM_ADDR_BITS (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_ready     (mem_ready),
    .address       (address),
    .mem_output    (mem_output),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_len       (err_len),
    .checksum_calc (checksum_calc),
    .checksum_rx   (checksum_rx)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM model.
  always @(posedge clock) mem_output <= mem[address];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: checksum straight from the frame definition.
  function automatic void model(output int edone, output logic [15:0] ecalc,
                                output logic [15:0] erx, output logic epass, output logic eerr);
    int L;
    int acc;
    L     = int'({mem[5], mem[4]});
    ecalc = 16'd0;
    erx   = 16'd0;
    if (L < 6 || L > 1022) begin
      eerr  = 1'b1;
      epass = 1'b0;
      edone = 7;
    end else begin
      acc = 0;
      for (int i = 0; i < L; i++) acc = acc + int'(mem[i]) * (1 << (i % 4));
      ecalc = 16'(acc % 65536);
      erx   = {mem[L+1], mem[L]};
      eerr  = 1'b0;
      epass = (ecalc == erx);
      edone = L + 3;
    end
  endfunction

  // Pulse mem_ready for one cycle and return the cycle (1 = first after start) in which done is seen.
  task automatic start_and_wait(input string nm, output int dcyc);
    @(negedge clock);
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    check({nm, "_busy_c1"}, 32'(busy), 32'd1);
    dcyc = -1;
    for (int k = 1; k <= 1200; k++) begin
      if (done) begin
        dcyc = k;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic verify(input string nm, input int dcyc, input int edone, input logic [15:0] ecalc,
                        input logic [15:0] erx, input logic epass, input logic eerr, input bit chk_sum);
    check({nm, "_done_cycle"}, 32'(dcyc), 32'(edone));
    check({nm, "_pass"}, 32'(pass), 32'(epass));
    check({nm, "_err_len"}, 32'(err_len), 32'(eerr));
    if (chk_sum) begin
      check({nm, "_calc"}, 32'(checksum_calc), 32'(ecalc));
      check({nm, "_rx"}, 32'(checksum_rx), 32'(erx));
    end
    @(negedge clock);
    check({nm, "_done_one_cycle"}, 32'(done), 32'd0);
    check({nm, "_idle_busy"}, 32'(busy), 32'd0);
    check({nm, "_idle_addr"}, 32'(address), 32'd0);
    check({nm, "_pass_hold"}, 32'(pass), 32'(epass));
  endtask

  typedef struct {
    string       nm;
    int          nb;
    logic [79:0] frame;   // byte j at bits [8j+7:8j]
    int          edone;
    logic [15:0] ecalc;
    logic [15:0] erx;
    logic        epass;
    logic        eerr;
    bit          chk_sum;
  } vec_t;

  vec_t tbl[5];

  task automatic load_vec(input int i);
    for (int j = 0; j < tbl[i].nb; j++) mem[j] = tbl[i].frame[8*j +: 8];
  endtask

  initial begin
    int          d;
    int          d1;
    int          d2;
    int          L;
    int          edone;
    logic [15:0] ecalc;
    logic [15:0] erx;
    logic [15:0] rxv;
    logic        epass;
    logic        eerr;
    bit          seen;

    tbl[0] = '{"len8_pass", 10, {8'h00, 8'h7D, 8'h06, 8'h05, 8'h00, 8'h08, 8'h04, 8'h03, 8'h02, 8'h01},
               11, 16'h007D, 16'h007D, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{"len8_badrx", 10, {8'h01, 8'h7D, 8'h06, 8'h05, 8'h00, 8'h08, 8'h04, 8'h03, 8'h02, 8'h01},
               11, 16'h007D, 16'h017D, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{"len5_err", 6, {32'h0, 8'h00, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
               7, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{"len6_min", 8, {16'h0, 8'h03, 8'h16, 8'h00, 8'h06, 8'h40, 8'h30, 8'h20, 8'h10},
               9, 16'h0316, 16'h0316, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{"lenffff_err", 6, {32'h0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
               7, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    reset     = 1'b1;
    mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_len), 32'd0);
    check("rst_calc", 32'(checksum_calc), 32'd0);
    check("rst_rx", 32'(checksum_rx), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      load_vec(i);
      start_and_wait(tbl[i].nm, d);
      verify(tbl[i].nm, d, tbl[i].edone, tbl[i].ecalc, tbl[i].erx, tbl[i].epass, tbl[i].eerr, tbl[i].chk_sum);
    end

    // Random frames against the reference model.
    for (int r = 0; r < 20; r++) begin
      if (r % 5 == 4) begin
        L = (r % 10 == 4) ? int'($urandom_range(0, 5)) : int'($urandom_range(1023, 65535));
        for (int j = 0; j < 8; j++) mem[j] = 8'($urandom);
        mem[4] = L[7:0];
        mem[5] = L[15:8];
      end else begin
        L = int'($urandom_range(6, 48));
        for (int j = 0; j < L + 2; j++) mem[j] = 8'($urandom);
        mem[4] = L[7:0];
        mem[5] = L[15:8];
        model(edone, ecalc, erx, epass, eerr);
        rxv = (r % 2 == 1) ? ecalc : (ecalc ^ 16'($urandom_range(1, 65535)));
        mem[L]   = rxv[7:0];
        mem[L+1] = rxv[15:8];
      end
      model(edone, ecalc, erx, epass, eerr);
      start_and_wait("rand", d);
      verify("rand", d, edone, ecalc, erx, epass, eerr, !eerr);
    end

    // Largest legal frame: all-FF payload wraps the 16-bit sum.
    for (int j = 0; j < 1022; j++) mem[j] = 8'hFF;
    mem[4] = 8'hFE;
    mem[5] = 8'h03;
    model(edone, ecalc, erx, epass, eerr);
    mem[1022] = ecalc[7:0];
    mem[1023] = ecalc[15:8];
    model(edone, ecalc, erx, epass, eerr);
    start_and_wait("len1022", d);
    verify("len1022", d, edone, ecalc, erx, epass, eerr, 1'b1);
    check("len1022_pass_model", 32'(pass), 32'd1);

    // One past the largest legal length.
    mem[4] = 8'hFF;
    mem[5] = 8'h03;
    start_and_wait("len1023", d);
    verify("len1023", d, 7, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of an L=8 check.
    load_vec(0);
    @(negedge clock);
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pass", 32'(pass), 32'd0);
    check("midrst_err", 32'(err_len), 32'd0);
    check("midrst_calc", 32'(checksum_calc), 32'd0);
    check("midrst_rx", 32'(checksum_rx), 32'd0);
    check("midrst_addr", 32'(address), 32'd0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clock);
      if (done || busy) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    start_and_wait("after_rst", d);
    verify("after_rst", d, 11, 16'h007D, 16'h007D, 1'b1, 1'b0, 1'b1);

    // mem_ready held high: back-to-back checks.
    @(negedge clock);
    mem_ready = 1'b1;
    @(negedge clock);
    d1 = -1;
    d2 = -1;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
        end else begin
          d2 = k;
          mem_ready = 1'b0;
        end
      end
      if (d2 >= 0) break;
      @(negedge clock);
    end
    check("hold_first_done", 32'(d1), 32'd11);
    check("hold_second_done", 32'(d2), 32'd23);
    repeat (2) @(negedge clock);
    check("hold_stops", 32'(busy), 32'd0);

    // mem_ready pulses while busy must not queue another check.
    @(negedge clock);
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    d = -1;
    for (int k = 1; k <= 40; k++) begin
      mem_ready = (k >= 3 && k <= 5) ? 1'b1 : 1'b0;
      if (done) begin
        d = k;
        break;
      end
      @(negedge clock);
    end
    mem_ready = 1'b0;
    check("ign_done", 32'(d), 32'd11);
    check("ign_pass", 32'(pass), 32'd1);
    @(negedge clock);
    check("ign_idle1", 32'(busy), 32'd0);
    @(negedge clock);
    check("ign_idle2", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
